// File: rtl/bus_device_responder.sv
// Device-side responder for the L1 variable-latency interconnect.
// Accepts one request at a time, replays it to a simple peripheral as a
// one-cycle pulse, waits (bounded) for the peripheral's answer and queues
// {initiator id, data} in a small response FIFO drained with resp_ready_i.
//
// Handshake semantics: a request transfers on a cycle where
// req_valid_i && req_ready_o; a response transfers on a cycle where
// resp_valid_o && resp_ready_i. req_ready_o never depends on req_valid_i,
// and the response head is held stable while it is not taken.
module bus_device_responder #(
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          AddrWidth     = 12,
    parameter int unsigned          HostIdWidth   = 1,
    parameter int unsigned          RespDepth     = 2,
    parameter int unsigned          TimeoutCycles = 16,
    parameter logic [DataWidth-1:0] ErrData       = 32'h0BADC0DE
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [HostIdWidth-1:0]   req_ini_addr_i,
    input  logic [AddrWidth-1:0]     req_tgt_addr_i,
    input  logic                     req_wen_i,
    input  logic [DataWidth-1:0]     req_wdata_i,
    input  logic [DataWidth/8-1:0]   req_be_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [HostIdWidth-1:0]   resp_ini_addr_o,
    output logic [DataWidth-1:0]     resp_rdata_o,
    output logic                     dev_req_o,
    output logic                     dev_we_o,
    output logic [DataWidth/8-1:0]   dev_be_o,
    output logic [AddrWidth-1:0]     dev_addr_o,
    output logic [DataWidth-1:0]     dev_wdata_o,
    input  logic                     dev_rvalid_i,
    input  logic [DataWidth-1:0]     dev_rdata_i,
    output logic                     timeout_o
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned PtrW    = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int unsigned CntW    = $clog2(RespDepth) + 1;
    localparam int unsigned TmoW    = $clog2(TimeoutCycles) + 1;
    localparam int unsigned EntryW  = HostIdWidth + DataWidth;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    typedef enum logic [0:0] {S_IDLE, S_WAIT} state_e;

    state_e                  state_q, state_d;
    logic [HostIdWidth-1:0]  id_q;
    logic [AddrWidth-1:0]    addr_q;
    logic                    we_q;
    logic [BeWidth-1:0]      be_q;
    logic [DataWidth-1:0]    wdata_q;
    logic                    dev_req_q;
    logic                    timeout_q;
    logic [TmoW-1:0]         tmo_cnt_q;

    logic [EntryW-1:0]       mem_q [RespDepth];
    logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]         count_q;

    logic                    ready_c, accept_c, push_c, pop_c, tmo_fire_c;
    logic [EntryW-1:0]       push_entry_c;
    logic [EntryW-1:0]       head_c;

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: leave IDLE on accept, return once a response is pushed
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_c) state_d = S_WAIT;
            S_WAIT:  if (push_c)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: ready in IDLE with a free FIFO slot; push on answer or timeout
    always_comb begin
        ready_c      = 1'b0;
        push_c       = 1'b0;
        push_entry_c = '0;
        tmo_fire_c   = 1'b0;
        case (state_q)
            S_IDLE: ready_c = !rst_i && (count_q < CntW'(RespDepth));
            S_WAIT: begin
                // a real answer beats a timeout landing on the same cycle
                if (dev_rvalid_i) begin
                    push_c       = 1'b1;
                    push_entry_c = {id_q, we_q ? {DataWidth{1'b0}} : dev_rdata_i};
                end else if (tmo_cnt_q == TmoLast) begin
                    push_c       = 1'b1;
                    push_entry_c = {id_q, ErrData};
                    tmo_fire_c   = 1'b1;
                end
            end
            default: ready_c = 1'b0;
        endcase
        accept_c = ready_c && req_valid_i;
    end

    // Request capture, peripheral pulse, timeout counter and timeout pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_q      <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            dev_req_q <= 1'b0;
            timeout_q <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            dev_req_q <= accept_c;
            timeout_q <= tmo_fire_c;
            if (accept_c) begin
                id_q      <= req_ini_addr_i;
                addr_q    <= req_tgt_addr_i;
                we_q      <= req_wen_i;
                be_q      <= req_be_i;
                wdata_q   <= req_wdata_i;
                tmo_cnt_q <= '0;
            end else if (state_q == S_WAIT && !push_c) begin
                tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
            end
        end
    end

    // Response FIFO storage; contents are masked by the empty flag on output
    always_ff @(posedge clk_i) begin
        if (push_c) mem_q[wr_ptr_q] <= push_entry_c;
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_c          = mem_q[rd_ptr_q];
    assign pop_c           = resp_valid_o && resp_ready_i;
    assign req_ready_o     = ready_c;
    assign resp_valid_o    = (count_q != '0);
    assign resp_rdata_o    = resp_valid_o ? head_c[DataWidth-1:0] : '0;
    assign resp_ini_addr_o = resp_valid_o ? head_c[EntryW-1 -: HostIdWidth] : '0;
    assign dev_req_o       = dev_req_q;
    assign dev_we_o        = we_q;
    assign dev_be_o        = be_q;
    assign dev_addr_o      = addr_q;
    assign dev_wdata_o     = wdata_q;
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_bus_device_responder.sv
// Directed bench for bus_device_responder: read/write latency, response
// backpressure, timeout with a late answer, pop+push overlap, reset in WAIT.
module tb_bus_device_responder;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [0:0]  req_ini_addr_i = '0;
    logic [11:0] req_tgt_addr_i = '0;
    logic        req_wen_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_be_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [0:0]  resp_ini_addr_o;
    logic [31:0] resp_rdata_o;
    logic        dev_req_o;
    logic        dev_we_o;
    logic [3:0]  dev_be_o;
    logic [11:0] dev_addr_o;
    logic [31:0] dev_wdata_o;
    logic        dev_rvalid_i = 1'b0;
    logic [31:0] dev_rdata_i = '0;
    logic        timeout_o;

    int total = 0;
    int bad   = 0;

    logic [85:0] all_outs;
    assign all_outs = {req_ready_o, resp_valid_o, resp_ini_addr_o, resp_rdata_o,
                       dev_req_o, dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o, timeout_o};

    bus_device_responder dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_ini_addr_i  (req_ini_addr_i),
        .req_tgt_addr_i  (req_tgt_addr_i),
        .req_wen_i       (req_wen_i),
        .req_wdata_i     (req_wdata_i),
        .req_be_i        (req_be_i),
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (resp_ready_i),
        .resp_ini_addr_o (resp_ini_addr_o),
        .resp_rdata_o    (resp_rdata_o),
        .dev_req_o       (dev_req_o),
        .dev_we_o        (dev_we_o),
        .dev_be_o        (dev_be_o),
        .dev_addr_o      (dev_addr_o),
        .dev_wdata_o     (dev_wdata_o),
        .dev_rvalid_i    (dev_rvalid_i),
        .dev_rdata_i     (dev_rdata_i),
        .timeout_o       (timeout_o)
    );

    // clock: 10 ns period
    always #5 clk_i = ~clk_i;

    // Driver: called at posedge+1; presents a request until accepted.
    // Returns at posedge+1 of the cycle after acceptance (dev_req_o cycle).
    task automatic send_req(input logic [0:0] ini, input logic [11:0] addr,
                            input logic wen, input logic [31:0] wdata, input logic [3:0] be);
        int n;
        n = 0;
        req_valid_i    = 1'b1;
        req_ini_addr_i = ini;
        req_tgt_addr_i = addr;
        req_wen_i      = wen;
        req_wdata_i    = wdata;
        req_be_i       = be;
        @(negedge clk_i);
        while (req_ready_o !== 1'b1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL accept_wait: req_ready_o never rose within 50 cycles");
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    // Driver: peripheral answers one cycle after dev_req_o (T+2); returns at T+3.
    task automatic serve(input logic [31:0] data);
        @(posedge clk_i); #1;
        dev_rvalid_i = 1'b1;
        dev_rdata_i  = data;
        @(posedge clk_i); #1;
        dev_rvalid_i = 1'b0;
        dev_rdata_i  = '0;
    endtask

    task automatic test_reset;
        #2;
        total++;
        if (all_outs !== '0) begin
            bad++; $display("FAIL reset_outs: got=%h exp=0", all_outs);
        end
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
            bad++; $display("FAIL reset_release: ready=%b valid=%b exp ready=1 valid=0",
                            req_ready_o, resp_valid_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_read;
        send_req(1'b1, 12'h004, 1'b0, 32'h0, 4'hF);
        @(negedge clk_i);
        total++;
        if (dev_req_o !== 1'b1 || dev_addr_o !== 12'h004 || dev_we_o !== 1'b0 || req_ready_o !== 1'b0) begin
            bad++; $display("FAIL read_devreq: req=%b addr=%h we=%b ready=%b exp 1 004 0 0",
                            dev_req_o, dev_addr_o, dev_we_o, req_ready_o);
        end
        @(posedge clk_i); #1;
        dev_rvalid_i = 1'b1; dev_rdata_i = 32'h12345678;
        @(negedge clk_i);
        total++;
        if (resp_valid_o !== 1'b0 || dev_req_o !== 1'b0) begin
            bad++; $display("FAIL read_t2: resp_valid=%b dev_req=%b exp 0 0", resp_valid_o, dev_req_o);
        end
        @(posedge clk_i); #1;
        dev_rvalid_i = 1'b0; dev_rdata_i = '0;
        @(negedge clk_i);
        total++;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'h12345678 || resp_ini_addr_o !== 1'b1) begin
            bad++; $display("FAIL read_resp: valid=%b rdata=%h ini=%b exp 1 12345678 1",
                            resp_valid_o, resp_rdata_o, resp_ini_addr_o);
        end
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            bad++; $display("FAIL read_drain: valid=%b ready=%b exp 0 1", resp_valid_o, req_ready_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_write;
        send_req(1'b0, 12'h008, 1'b1, 32'hA5A5A5A5, 4'hF);
        @(negedge clk_i);
        total++;
        if (dev_req_o !== 1'b1 || dev_we_o !== 1'b1 || dev_wdata_o !== 32'hA5A5A5A5 ||
            dev_be_o !== 4'hF || dev_addr_o !== 12'h008) begin
            bad++; $display("FAIL write_devreq: req=%b we=%b wdata=%h be=%h addr=%h exp 1 1 a5a5a5a5 f 008",
                            dev_req_o, dev_we_o, dev_wdata_o, dev_be_o, dev_addr_o);
        end
        serve(32'hDEADBEEF);
        @(negedge clk_i);
        total++;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'h0 || resp_ini_addr_o !== 1'b0) begin
            bad++; $display("FAIL write_resp: valid=%b rdata=%h ini=%b exp 1 00000000 0",
                            resp_valid_o, resp_rdata_o, resp_ini_addr_o);
        end
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
    endtask

    task automatic test_backpressure;
        int early;
        send_req(1'b0, 12'h010, 1'b0, 32'h0, 4'hF);
        serve(32'h11111111);
        send_req(1'b1, 12'h014, 1'b0, 32'h0, 4'hF);
        serve(32'h22222222);
        // third request held off while both slots are occupied
        req_valid_i = 1'b1; req_ini_addr_i = 1'b0; req_tgt_addr_i = 12'h018;
        req_wen_i = 1'b0; req_be_i = 4'hF;
        early = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            if (req_ready_o !== 1'b0 || dev_req_o !== 1'b0) early++;
            @(posedge clk_i); #1;
        end
        total++;
        if (early != 0) begin
            bad++; $display("FAIL bp_blocked: ready/dev_req high on %0d cycles exp 0", early);
        end
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'h11111111 || resp_ini_addr_o !== 1'b0 || req_ready_o !== 1'b0) begin
            bad++; $display("FAIL bp_first: valid=%b rdata=%h ini=%b ready=%b exp 1 11111111 0 0",
                            resp_valid_o, resp_rdata_o, resp_ini_addr_o, req_ready_o);
        end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        total++;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'h22222222 || resp_ini_addr_o !== 1'b1 || req_ready_o !== 1'b1) begin
            bad++; $display("FAIL bp_second: valid=%b rdata=%h ini=%b ready=%b exp 1 22222222 1 1",
                            resp_valid_o, resp_rdata_o, resp_ini_addr_o, req_ready_o);
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0; resp_ready_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (dev_req_o !== 1'b1 || dev_addr_o !== 12'h018 || resp_valid_o !== 1'b0) begin
            bad++; $display("FAIL bp_third_req: dev_req=%b addr=%h valid=%b exp 1 018 0",
                            dev_req_o, dev_addr_o, resp_valid_o);
        end
        serve(32'h33333333);
        @(negedge clk_i);
        total++;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'h33333333) begin
            bad++; $display("FAIL bp_third_resp: valid=%b rdata=%h exp 1 33333333", resp_valid_o, resp_rdata_o);
        end
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
    endtask

    task automatic test_timeout;
        int early;
        send_req(1'b1, 12'h020, 1'b0, 32'h0, 4'hF);
        // dev_req_o cycle is k=0; timeout pulse expected at k=16
        early = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_i);
            if (timeout_o !== 1'b0 || resp_valid_o !== 1'b0) early++;
            @(posedge clk_i); #1;
        end
        total++;
        if (early != 0) begin
            bad++; $display("FAIL tmo_early: timeout/resp seen on %0d cycles before k=16 exp 0", early);
        end
        @(negedge clk_i);
        total++;
        if (timeout_o !== 1'b1 || resp_valid_o !== 1'b1 || resp_rdata_o !== 32'h0BADC0DE || resp_ini_addr_o !== 1'b1) begin
            bad++; $display("FAIL tmo_fire: tmo=%b valid=%b rdata=%h ini=%b exp 1 1 0badc0de 1",
                            timeout_o, resp_valid_o, resp_rdata_o, resp_ini_addr_o);
        end
        @(posedge clk_i); #1;
        dev_rvalid_i = 1'b1; dev_rdata_i = 32'h77777777;   // late answer
        @(negedge clk_i);
        total++;
        if (timeout_o !== 1'b0) begin
            bad++; $display("FAIL tmo_pulse_width: tmo=%b exp 0", timeout_o);
        end
        @(posedge clk_i); #1;
        dev_rvalid_i = 1'b0; dev_rdata_i = '0;
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            bad++; $display("FAIL tmo_late_ignored: valid=%b ready=%b exp 0 1", resp_valid_o, req_ready_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_pop_push;
        send_req(1'b0, 12'h030, 1'b0, 32'h0, 4'hF);
        serve(32'hAAAA0001);
        send_req(1'b1, 12'h034, 1'b0, 32'h0, 4'hF);
        @(posedge clk_i); #1;
        dev_rvalid_i = 1'b1; dev_rdata_i = 32'hBBBB0002; resp_ready_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'hAAAA0001) begin
            bad++; $display("FAIL pp_head_a: valid=%b rdata=%h exp 1 aaaa0001", resp_valid_o, resp_rdata_o);
        end
        @(posedge clk_i); #1;
        dev_rvalid_i = 1'b0; dev_rdata_i = '0; resp_ready_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'hBBBB0002 || resp_ini_addr_o !== 1'b1 || req_ready_o !== 1'b1) begin
            bad++; $display("FAIL pp_head_b: valid=%b rdata=%h ini=%b ready=%b exp 1 bbbb0002 1 1",
                            resp_valid_o, resp_rdata_o, resp_ini_addr_o, req_ready_o);
        end
        @(posedge clk_i); #1;
        send_req(1'b0, 12'h038, 1'b0, 32'h0, 4'hF);
        serve(32'hCCCC0003);
        resp_ready_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (req_ready_o !== 1'b0 || resp_rdata_o !== 32'hBBBB0002) begin
            bad++; $display("FAIL pp_full: ready=%b rdata=%h exp 0 bbbb0002", req_ready_o, resp_rdata_o);
        end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        total++;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'hCCCC0003 || resp_ini_addr_o !== 1'b0) begin
            bad++; $display("FAIL pp_head_c: valid=%b rdata=%h ini=%b exp 1 cccc0003 0",
                            resp_valid_o, resp_rdata_o, resp_ini_addr_o);
        end
        @(posedge clk_i); #1;
        resp_ready_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (resp_valid_o !== 1'b0) begin
            bad++; $display("FAIL pp_empty: valid=%b exp 0", resp_valid_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_in_wait;
        send_req(1'b1, 12'h040, 1'b0, 32'h0, 4'hF);
        serve(32'h44444444);
        send_req(1'b1, 12'h0FC, 1'b1, 32'h5A5A1234, 4'h3);
        #2;
        rst_i = 1'b1;
        #1;
        total++;
        if (all_outs !== '0) begin
            bad++; $display("FAIL rst_wait_outs: got=%h exp=0", all_outs);
        end
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || dev_req_o !== 1'b0) begin
            bad++; $display("FAIL rst_wait_release: ready=%b valid=%b dev_req=%b exp 1 0 0",
                            req_ready_o, resp_valid_o, dev_req_o);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        total++;
        if (resp_valid_o !== 1'b0 || timeout_o !== 1'b0) begin
            bad++; $display("FAIL rst_wait_stale: valid=%b tmo=%b exp 0 0", resp_valid_o, timeout_o);
        end
    endtask

    initial begin
        test_reset;
        test_read;
        test_write;
        test_backpressure;
        test_timeout;
        test_pop_push;
        test_reset_in_wait;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
